rt_stream_receiver: RTL

//  Receiving end of the r/t constant transfer. Collects the MSB-first 64-bit word

---
 rtl/rt_stream_receiver.sv | 138 +++++++++++++
 1 files changed

// File: rtl/rt_stream_receiver.sv
// rtl/rt_stream_receiver.sv - reassembles streamed r/t Montgomery constants into full operands
//
// Purpose: collects MSB-first DATA_WIDTH-bit words of r and t, plus n0', into
// DATA_LENGTH-bit operands and holds them until the consumer acknowledges.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   start_transfer                  level from transmitter, rising edge opens a frame
//   word_valid, r_word, t_word      incoming word pair
//   n0p_in                          n0' constant, latched on the frame-opening edge
//   result_ack                      consumer has taken the held result
//   r_out, t_out, n0p_out           reassembled operands
//   word_count, busy, result_valid  progress / status
//   overrun                         sticky protocol-error flag
module rt_stream_receiver #(
  parameter int DATA_WIDTH  = 64,
  parameter int DATA_LENGTH = 4096,
  parameter int CNT_WIDTH   = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_transfer,
  input  logic                   word_valid,
  input  logic [DATA_WIDTH-1:0]  r_word,
  input  logic [DATA_WIDTH-1:0]  t_word,
  input  logic [DATA_WIDTH-1:0]  n0p_in,
  input  logic                   result_ack,
  output logic [DATA_LENGTH-1:0] r_out,
  output logic [DATA_LENGTH-1:0] t_out,
  output logic [DATA_WIDTH-1:0]  n0p_out,
  output logic [CNT_WIDTH-1:0]   word_count,
  output logic                   busy,
  output logic                   result_valid,
  output logic                   overrun
);

  localparam int NUM_WORDS = DATA_LENGTH / DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, RECV, HOLD} state_e;

  state_e                 state_q, state_d;
  logic                   start_q;
  logic [DATA_LENGTH-1:0] r_sh_q, t_sh_q;
  logic [DATA_LENGTH-1:0] r_out_q, t_out_q;
  logic [DATA_WIDTH-1:0]  n0p_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic                   ovr_q, rv_q;

  logic                   edge_w;
  logic                   last_w;
  logic [DATA_LENGTH-1:0] r_sh_next, t_sh_next;

  assign edge_w    = start_transfer & ~start_q;
  // An edge in RECV restarts the frame, so the last-word condition excludes it.
  assign last_w    = (state_q == RECV) && !edge_w && word_valid && (cnt_q == LAST_IDX);
  assign r_sh_next = {r_sh_q[DATA_LENGTH-DATA_WIDTH-1:0], r_word};
  assign t_sh_next = {t_sh_q[DATA_LENGTH-DATA_WIDTH-1:0], t_word};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (edge_w) state_d = RECV;
      RECV:    if (edge_w) state_d = RECV;
               else if (last_w) state_d = HOLD;
      HOLD:    if (result_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == RECV);
  end

  assign r_out        = r_out_q;
  assign t_out        = t_out_q;
  assign n0p_out      = n0p_q;
  assign word_count   = cnt_q;
  assign result_valid = rv_q;
  assign overrun      = ovr_q;

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      r_sh_q  <= '0;
      t_sh_q  <= '0;
      r_out_q <= '0;
      t_out_q <= '0;
      n0p_q   <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      start_q <= start_transfer;
      case (state_q)
        IDLE, RECV: begin
          if (edge_w) begin
            n0p_q <= n0p_in;
            // A restart from RECV keeps the error flag; only a fresh frame clears it.
            if (state_q == IDLE) ovr_q <= 1'b0;
            if (word_valid) begin
              r_sh_q <= {{(DATA_LENGTH-DATA_WIDTH){1'b0}}, r_word};
              t_sh_q <= {{(DATA_LENGTH-DATA_WIDTH){1'b0}}, t_word};
              cnt_q  <= CNT_WIDTH'(1);
            end else begin
              r_sh_q <= '0;
              t_sh_q <= '0;
              cnt_q  <= '0;
            end
          end else if (state_q == RECV && word_valid) begin
            r_sh_q <= r_sh_next;
            t_sh_q <= t_sh_next;
            cnt_q  <= cnt_q + CNT_WIDTH'(1);
            if (last_w) begin
              r_out_q <= r_sh_next;
              t_out_q <= t_sh_next;
              rv_q    <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (word_valid || edge_w) ovr_q <= 1'b1;
          if (result_ack)           rv_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
